// File: rtl/id_pkg.sv
// Shared constants for the MIPS instruction-decode stage.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;

    localparam logic [31:0] NOP_INST = 32'h0;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/id_stage_reg_file.sv
// 32x32 register file: two write-first read ports, one write port, r0 hardwired to zero.
module reg_file
    import id_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_en;

    assign wr_en = we_i && (wa_i != REG_ZERO);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wa_i] = wd_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Same-cycle writeback is bypassed so ID sees the value being written.
    always_comb begin
        rd1_o = 32'h0;
        rd2_o = 32'h0;
        if (ra1_i != REG_ZERO) begin
            rd1_o = (wr_en && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
        end
        if (ra2_i != REG_ZERO) begin
            rd2_o = (wr_en && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS ID stage: IF/ID register, register file, beq/bne/j resolution and hazard detection.
// Define ID_BNE_EN to decode bne as a branch; otherwise opcode 000101 is a plain instruction.
module id_stage
    import id_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] nextInstAdr,
    input  logic [31:0] Inst,
    input  logic        wbRegWrite,
    input  logic [4:0]  wbWriteReg,
    input  logic [31:0] wbWriteData,
    input  logic        exRegWrite,
    input  logic        exMemRead,
    input  logic [4:0]  exWriteReg,
    input  logic        memRegWrite,
    input  logic [4:0]  memWriteReg,
    output logic        pcWrite,
    output logic        flush,
    output logic        PcSrc,
    output logic        jmp,
    output logic [31:0] beqAdr,
    output logic [25:0] jmpAdr,
    output logic [31:0] readData1,
    output logic [31:0] readData2,
    output logic [31:0] signExtImm,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] idPc4,
    output logic        idExBubble
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] rf_rd1, rf_rd2;
    logic [5:0]  op_f;
    logic [4:0]  rs_f, rt_f;
    logic [31:0] imm_ext;
    logic        is_j, is_beq, is_bne, is_br;
    logic        ex_hit, mem_hit, load_use, br_haz, stall, taken;

    assign op_f    = instr_q[31:26];
    assign rs_f    = instr_q[25:21];
    assign rt_f    = instr_q[20:16];
    assign imm_ext = {{16{instr_q[15]}}, instr_q[15:0]};

    reg_file u_reg_file (
        .clk_i (clk),
        .rst_i (rst),
        .ra1_i (rs_f),
        .ra2_i (rt_f),
        .we_i  (wbRegWrite),
        .wa_i  (wbWriteReg),
        .wd_i  (wbWriteData),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2)
    );

    always_comb begin
        is_j   = (op_f == OP_J);
        is_beq = (op_f == OP_BEQ);
`ifdef ID_BNE_EN
        is_bne = (op_f == OP_BNE);
`else
        is_bne = 1'b0;
`endif
        is_br    = is_beq || is_bne;
        ex_hit   = (exWriteReg != REG_ZERO) && (exWriteReg == rs_f || exWriteReg == rt_f);
        mem_hit  = (memWriteReg != REG_ZERO) && (memWriteReg == rs_f || memWriteReg == rt_f);
        load_use = exMemRead && ex_hit && !is_j;
        br_haz   = is_br && ((exRegWrite && ex_hit) || (memRegWrite && mem_hit));
        stall    = load_use || br_haz;
        taken    = (is_beq && (rf_rd1 == rf_rd2)) || (is_bne && (rf_rd1 != rf_rd2));
    end

    always_comb begin
        instr_d = stall ? instr_q : Inst;
        pc4_d   = stall ? pc4_q : nextInstAdr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INST;
            pc4_q   <= 32'h0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    // While reset is held every output shows its cleared value, independent of pending state.
    always_comb begin
        pcWrite    = 1'b1;
        idExBubble = 1'b0;
        PcSrc      = 1'b0;
        jmp        = 1'b0;
        flush      = 1'b0;
        beqAdr     = 32'h0;
        jmpAdr     = 26'h0;
        readData1  = 32'h0;
        readData2  = 32'h0;
        signExtImm = 32'h0;
        rs         = 5'd0;
        rt         = 5'd0;
        rd         = 5'd0;
        opcode     = 6'd0;
        funct      = 6'd0;
        idPc4      = 32'h0;
        if (!rst) begin
            pcWrite    = !stall;
            idExBubble = stall;
            PcSrc      = taken && !stall;
            jmp        = is_j && !stall;
            flush      = (taken || is_j) && !stall;
            beqAdr     = pc4_q + {imm_ext[29:0], 2'b00};
            jmpAdr     = instr_q[25:0];
            readData1  = rf_rd1;
            readData2  = rf_rd2;
            signExtImm = imm_ext;
            rs         = rs_f;
            rt         = rt_f;
            rd         = instr_q[15:11];
            opcode     = op_f;
            funct      = instr_q[5:0];
            idPc4      = pc4_q;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the ID stage.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] nextInstAdr, raw_inst, Inst;
    logic        wbRegWrite, exRegWrite, exMemRead, memRegWrite;
    logic [4:0]  wbWriteReg, exWriteReg, memWriteReg;
    logic [31:0] wbWriteData;
    logic        pcWrite, flush, PcSrc, jmp, idExBubble;
    logic [31:0] beqAdr, readData1, readData2, signExtImm, idPc4;
    logic [25:0] jmpAdr;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  opcode, funct;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef ID_BNE_EN
    localparam bit BneEn = 1'b1;
`else
    localparam bit BneEn = 1'b0;
`endif

    always #5 clk = ~clk;

    // Fetch zeroes the instruction it hands over when ID asks for a flush.
    assign Inst = flush ? 32'h0 : raw_inst;

    id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .nextInstAdr (nextInstAdr),
        .Inst        (Inst),
        .wbRegWrite  (wbRegWrite),
        .wbWriteReg  (wbWriteReg),
        .wbWriteData (wbWriteData),
        .exRegWrite  (exRegWrite),
        .exMemRead   (exMemRead),
        .exWriteReg  (exWriteReg),
        .memRegWrite (memRegWrite),
        .memWriteReg (memWriteReg),
        .pcWrite     (pcWrite),
        .flush       (flush),
        .PcSrc       (PcSrc),
        .jmp         (jmp),
        .beqAdr      (beqAdr),
        .jmpAdr      (jmpAdr),
        .readData1   (readData1),
        .readData2   (readData2),
        .signExtImm  (signExtImm),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .opcode      (opcode),
        .funct       (funct),
        .idPc4       (idPc4),
        .idExBubble  (idExBubble)
    );

    // Behavioural model state: architectural registers plus the instruction sitting in ID.
    logic [31:0] m_regs [32];
    logic [31:0] m_instr, m_pc4;
    logic        e_stall, e_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value the ID stage should see for register r this cycle (writeback visible immediately).
    function automatic logic [31:0] reg_view(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wbRegWrite && wbWriteReg == r) return wbWriteData;
        return m_regs[r];
    endfunction

    task automatic settle();
        logic [5:0]  op;
        logic [4:0]  s, t;
        logic [31:0] v1, v2, imm, tgt;
        bit is_j, is_beq, is_bne, reads_ex, reads_mem, hazard, take;
        #1;
        op  = m_instr[31:26];
        s   = m_instr[25:21];
        t   = m_instr[20:16];
        v1  = reg_view(s);
        v2  = reg_view(t);
        imm = 32'($signed(m_instr[15:0]));
        tgt = m_pc4 + imm * 4;
        is_j   = (op == 6'd2);
        is_beq = (op == 6'd4);
        is_bne = BneEn && (op == 6'd5);
        // A jump reads no registers; everything else reads both rs and rt.
        reads_ex  = !is_j && exWriteReg != 0 && (exWriteReg == s || exWriteReg == t);
        reads_mem = !is_j && memWriteReg != 0 && (memWriteReg == s || memWriteReg == t);
        hazard = (exMemRead && reads_ex) ||
                 ((is_beq || is_bne) && ((exRegWrite && reads_ex) || (memRegWrite && reads_mem)));
        take = (is_beq && v1 == v2) || (is_bne && v1 != v2);
        if (rst) begin
            hazard = 0; take = 0; is_j = 0;
            v1 = 0; v2 = 0; imm = 0; tgt = 0; op = 0; s = 0; t = 0;
        end
        e_stall = hazard;
        e_flush = !hazard && (take || is_j);
        chk("pcWrite", 32'(pcWrite), 32'(!hazard));
        chk("idExBubble", 32'(idExBubble), 32'(hazard));
        chk("PcSrc", 32'(PcSrc), 32'(!hazard && take));
        chk("jmp", 32'(jmp), 32'(!hazard && is_j));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("readData1", readData1, v1);
        chk("readData2", readData2, v2);
        chk("signExtImm", signExtImm, imm);
        chk("beqAdr", beqAdr, tgt);
        chk("jmpAdr", 32'(jmpAdr), rst ? 32'h0 : 32'(m_instr[25:0]));
        chk("fields", {11'd0, opcode, rs, rt, rd}, rst ? 32'h0 : {11'd0, op, s, t, m_instr[15:11]});
        chk("funct", 32'(funct), rst ? 32'h0 : 32'(m_instr[5:0]));
        chk("idPc4", idPc4, rst ? 32'h0 : m_pc4);
    endtask

    task automatic advance();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_instr = 32'h0;
            m_pc4   = 32'h0;
        end else begin
            if (wbRegWrite && wbWriteReg != 0) m_regs[wbWriteReg] = wbWriteData;
            if (!e_stall) begin
                m_instr = e_flush ? 32'h0 : raw_inst;
                m_pc4   = nextInstAdr;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic quiet();
        wbRegWrite = 0; wbWriteReg = 0; wbWriteData = 0;
        exRegWrite = 0; exMemRead = 0; exWriteReg = 0;
        memRegWrite = 0; memWriteReg = 0;
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_instr = 32'h0; m_pc4 = 32'h0;
        rst = 1; raw_inst = 0; nextInstAdr = 32'h4;
        quiet();
        wbRegWrite = 1; wbWriteReg = 5'd3; wbWriteData = 32'hAAAA;  // dropped by reset
        @(negedge clk);
        step();
        step();
        quiet();
        rst = 0;

        // Nop stream: idPc4 follows nextInstAdr one cycle late.
        for (int i = 0; i < 3; i++) begin
            nextInstAdr = 32'h100 + 32'(i) * 4;
            step();
        end
        chk("idPc4_lag", idPc4, 32'h108);

        // Write-first read of r8 and a write to r0.
        raw_inst = {6'd0, 5'd8, 5'd0, 5'd10, 5'd0, 6'h20};
        step();
        raw_inst = 0;
        wbRegWrite = 1; wbWriteReg = 5'd8; wbWriteData = 32'h1234;
        settle();
        chk("wb_bypass_r8", readData1, 32'h1234);
        advance();
        wbWriteReg = 5'd0; wbWriteData = 32'hFFFF_FFFF;
        raw_inst = {6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20};
        settle();
        chk("r0_write_ignored", readData2, 32'h0);
        advance();

        // Load-use on r9.
        wbWriteReg = 5'd9; wbWriteData = 32'd7;
        step();
        wbWriteReg = 5'd11; wbWriteData = 32'd3;
        raw_inst = {6'd0, 5'd9, 5'd11, 5'd10, 5'd0, 6'h20};
        step();
        quiet();
        raw_inst = 32'h0123_4567;
        exMemRead = 1; exRegWrite = 1; exWriteReg = 5'd9;
        settle();
        chk("lu_pcWrite", 32'(pcWrite), 32'h0);
        chk("lu_bubble", 32'(idExBubble), 32'h1);
        advance();
        quiet();
        settle();
        chk("lu_held_rs", 32'(rs), 32'd9);
        chk("lu_release", 32'(pcWrite), 32'h1);
        advance();

        // Taken beq r1,r2,+3 from idPc4 = 0x40.
        wbRegWrite = 1; wbWriteReg = 5'd1; wbWriteData = 32'd5;
        raw_inst = 0;
        step();
        wbWriteReg = 5'd2;
        raw_inst = itype(6'd4, 5'd1, 5'd2, 16'd3);
        nextInstAdr = 32'h40;
        step();
        quiet();
        raw_inst = 32'hFFFF_FFFF;
        nextInstAdr = 32'h44;
        settle();
        chk("beq_PcSrc", 32'(PcSrc), 32'h1);
        chk("beq_flush", 32'(flush), 32'h1);
        chk("beq_target", beqAdr, 32'h4C);
        advance();
        raw_inst = 0;
        settle();
        chk("beq_squashed", {opcode, rs, rt}, 16'h0);
        advance();

        // beq r1,r2 with its producer in EX, then MEM.
        raw_inst = itype(6'd4, 5'd1, 5'd2, 16'hFFFE);
        step();
        raw_inst = 32'h2222_2222;
        exRegWrite = 1; exWriteReg = 5'd1;
        settle();
        chk("bex_stall", 32'(pcWrite), 32'h0);
        chk("bex_noPcSrc", 32'(PcSrc), 32'h0);
        advance();
        quiet();
        memRegWrite = 1; memWriteReg = 5'd1;
        settle();
        chk("bmem_stall", 32'(idExBubble), 32'h1);
        advance();
        quiet();
        settle();
        chk("b_resolved", 32'(PcSrc), 32'h1);
        advance();

        // Jump, then bne with unequal operands.
        raw_inst = {6'd2, 26'h0000010};
        step();
        raw_inst = 0;
        settle();
        chk("j_jmp", 32'(jmp), 32'h1);
        chk("j_adr", 32'(jmpAdr), 32'h10);
        advance();
        wbRegWrite = 1; wbWriteReg = 5'd3; wbWriteData = 32'd9;
        raw_inst = itype(6'd5, 5'd1, 5'd3, 16'd2);
        step();
        quiet();
        raw_inst = 0;
        settle();
        chk("bne_PcSrc", 32'(PcSrc), 32'(BneEn));
        advance();

        // Randomized traffic over a small register window to provoke hazards and equal operands.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] op;
            case ($urandom_range(5))
                0: op = 6'd4;
                1: op = 6'd5;
                2: op = 6'd2;
                3: op = 6'h23;
                default: op = 6'd0;
            endcase
            rst = ($urandom_range(99) == 0);
            raw_inst = itype(op, 5'($urandom_range(7)), 5'($urandom_range(7)), 16'($urandom));
            nextInstAdr = {$urandom_range(32'h3FFF_FFFF), 2'b00};
            wbRegWrite = ($urandom_range(2) != 0);
            wbWriteReg = 5'($urandom_range(7));
            wbWriteData = ($urandom_range(1) == 0) ? 32'd5 : $urandom;
            exMemRead = ($urandom_range(4) == 0);
            exRegWrite = ($urandom_range(2) == 0);
            exWriteReg = 5'($urandom_range(7));
            memRegWrite = ($urandom_range(2) == 0);
            memWriteReg = 5'($urandom_range(7));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
